// File: rtl/matmul_host_ctrl.sv
// Memory-mapped host controller for the flattened-operand matrix multiplier:
// packs CPU word writes into A/B buses, sequences the run, serves C and status.
module matmul_host_ctrl #(
  parameter int          ORDER     = 2,
  parameter int          BITWIDTH  = 32,
  parameter logic [31:0] BASE_ADDR = 32'h0200_0000
) (
  input  logic                                  clk,
  input  logic                                  reset,
  input  logic                                  mem_valid,
  input  logic [31:0]                           mem_addr,
  input  logic [31:0]                           mem_wdata,
  input  logic [3:0]                            mem_wstrb,
  output logic                                  mem_ready,
  output logic [31:0]                           mem_rdata,
  output logic                                  mm_reset,
  output logic                                  mm_enable,
  output logic [0:ORDER*ORDER*BITWIDTH-1]       mm_a,
  output logic [0:ORDER*ORDER*BITWIDTH-1]       mm_b,
  input  logic [0:ORDER*ORDER*BITWIDTH-1]       mm_c,
  input  logic                                  mm_rdy,
  output logic                                  irq
);

  localparam int NN = ORDER * ORDER;
  localparam int IW = (NN > 1) ? $clog2(NN) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_CLR,
    S_RUN
  } state_t;

  state_t state;

  logic [31:0]         a_word [NN];
  logic [31:0]         b_word [NN];
  logic [BITWIDTH-1:0] c_elem [NN];

  logic done;
  logic err;
  logic busy;

  logic       in_win;
  logic [1:0] region;
  logic [5:0] idx;
  logic [IW-1:0] k;
  logic       idx_ok;
  logic       req;
  logic       wr;
  logic       rd;
  logic       is_a;
  logic       is_b;
  logic       is_c;
  logic       is_ctrl;
  logic       is_stat;
  logic [31:0] rd_val;
  logic       unused_bits;

  assign busy   = (state != S_IDLE);
  assign in_win = (mem_addr[31:10] == BASE_ADDR[31:10]);
  assign region = mem_addr[9:8];
  assign idx    = mem_addr[7:2];
  assign k      = idx[IW-1:0];
  assign idx_ok = ({1'b0, idx} < 7'(NN));

  // The ~mem_ready term stops a still-held request from acting twice.
  assign req = mem_valid & in_win & ~mem_ready;
  assign wr  = req & (mem_wstrb != 4'b0000);
  assign rd  = req & (mem_wstrb == 4'b0000);

  assign is_a    = (region == 2'd0) & idx_ok;
  assign is_b    = (region == 2'd1) & idx_ok;
  assign is_c    = (region == 2'd2) & idx_ok;
  assign is_ctrl = (mem_addr[9:2] == 8'hC0);
  assign is_stat = (mem_addr[9:2] == 8'hC1);

  assign unused_bits = ^mem_addr[1:0];

  function automatic logic [31:0] merge(
    input logic [31:0] old,
    input logic [31:0] d,
    input logic [3:0]  s
  );
    logic [31:0] r;
    r = old;
    for (int i = 0; i < 4; i++) begin
      if (s[i]) r[i*8 +: 8] = d[i*8 +: 8];
    end
    return r;
  endfunction

  always_comb begin
    rd_val = '0;
    unique case (1'b1)
      is_a:    rd_val = a_word[k];
      is_b:    rd_val = b_word[k];
      is_c:    rd_val = 32'($signed(c_elem[k]));
      is_stat: rd_val = {29'b0, err, done, busy};
      default: rd_val = '0;
    endcase
  end

  for (genvar g = 0; g < NN; g++) begin : g_pack
    assign mm_a[g*BITWIDTH +: BITWIDTH] = a_word[g][BITWIDTH-1:0];
    assign mm_b[g*BITWIDTH +: BITWIDTH] = b_word[g][BITWIDTH-1:0];
  end

  // The multiplier is held in reset together with this block.
  assign mm_reset = reset | (state == S_CLR);
  assign irq      = done;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= S_IDLE;
      mem_ready <= 1'b0;
      mem_rdata <= '0;
      mm_enable <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
      for (int i = 0; i < NN; i++) begin
        a_word[i] <= '0;
        b_word[i] <= '0;
        c_elem[i] <= '0;
      end
    end else begin
      mem_ready <= req;
      mem_rdata <= rd ? rd_val : '0;

      if (wr && (is_a || is_b)) begin
        if (busy) begin
          err <= 1'b1;
        end else if (is_a) begin
          a_word[k] <= merge(a_word[k], mem_wdata, mem_wstrb);
        end else begin
          b_word[k] <= merge(b_word[k], mem_wdata, mem_wstrb);
        end
      end

      if (wr && is_ctrl && mem_wstrb[0]) begin
        if (mem_wdata[1]) done <= 1'b0;
        if (mem_wdata[0]) begin
          if (busy) begin
            err <= 1'b1;
          end else begin
            err   <= 1'b0;
            done  <= 1'b0;
            state <= S_CLR;
          end
        end
      end

      case (state)
        S_CLR: begin
          state     <= S_RUN;
          mm_enable <= 1'b1;
        end
        S_RUN: begin
          if (mm_rdy) begin
            for (int i = 0; i < NN; i++) begin
              c_elem[i] <= mm_c[i*BITWIDTH +: BITWIDTH];
            end
            done      <= 1'b1;
            state     <= S_IDLE;
            mm_enable <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
